// File: rtl/button_event_queue.sv
// Debounced active-low pushbutton: each accepted press pushes the current
// seconds timestamp into a small FIFO, with a sticky overflow flag.
module button_event_queue #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pushbutton,
    input  logic [15:0]             time_in,
    input  logic                    event_ack,
    input  logic                    clr_ovf,
    output logic                    event_ready,
    output logic [15:0]             event_time,
    output logic [$clog2(DEPTH):0]  event_count,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = 20;
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NW-1:0] FULL = NW'(DEPTH);

    logic          sync_1;
    logic          sync_2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          press;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [NW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          ovf_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= pushbutton;
            sync_2 <= sync_1;
        end
    end

    // A press is the debounced level completing its 1->0 transition.
    assign press = (sync_2 != stable) && (cnt == LIMIT) && !sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (sync_2 == stable) begin
            cnt <= '0;
        end else if (cnt == LIMIT) begin
            stable <= sync_2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign full    = (count == FULL);
    assign empty   = (count == '0);
    assign pop     = event_ack && !empty;
    // Popping a full FIFO frees the slot the new press lands in.
    assign push    = press && (!full || pop);
    assign ovf_set = press && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= time_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + NW'(1);
            end else if (pop && !push) begin
                count <= count - NW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign event_ready = !empty;
    assign event_time  = empty ? 16'h0000 : mem[rd_ptr];
    assign event_count = count;

endmodule

// File: tb/tb_button_event_queue.sv
// Scoreboard bench for button_event_queue: a queue-based reference model
// predicts outputs per edge; a monitor compares them on the falling edge.
module tb_button_event_queue;
    localparam int D = 4;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pushbutton = 1'b1;
    logic [15:0] time_in = 16'h0000;
    logic        event_ack = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        event_ready;
    logic [15:0] event_time;
    logic [2:0]  event_count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    button_event_queue #(
        .DEBOUNCE_CYCLES(D),
        .DEPTH(N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pushbutton(pushbutton),
        .time_in(time_in),
        .event_ack(event_ack),
        .clr_ovf(clr_ovf),
        .event_ready(event_ready),
        .event_time(event_time),
        .event_count(event_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic [15:0] tm;
        logic [2:0]  cnt;
        logic        ovf;
    } obs_t;

    obs_t exp_q[$];

    // Reference model: button seen two edges late, a run of D differing
    // edges flips the level, presses are timestamps in a bounded queue.
    logic        hist[$];
    int          run = 0;
    logic        lvl_stable = 1'b1;
    logic [15:0] fq[$];
    logic        movf = 1'b0;

    always @(posedge clk) begin
        logic lvl;
        logic prs;
        obs_t e;
        if (!rst_n) begin
            hist = '{1'b1, 1'b1};
            run = 0;
            lvl_stable = 1'b1;
            fq.delete();
            movf = 1'b0;
        end else begin
            lvl = hist.pop_front();
            hist.push_back(pushbutton);
            prs = 1'b0;
            if (lvl == lvl_stable) begin
                run = 0;
            end else begin
                run++;
                if (run == D) begin
                    lvl_stable = lvl;
                    run = 0;
                    prs = !lvl;
                end
            end
            if (event_ack && fq.size() != 0) void'(fq.pop_front());
            if (prs && fq.size() >= N) movf = 1'b1;
            else if (clr_ovf) movf = 1'b0;
            if (prs && fq.size() < N) fq.push_back(time_in);
        end
        e.rdy = (fq.size() != 0);
        e.tm  = (fq.size() != 0) ? fq[0] : 16'h0000;
        e.cnt = 3'(fq.size());
        e.ovf = movf;
        exp_q.push_back(e);
    end

    logic prev_rst = 1'b0;

    always @(negedge clk or negedge rst_n) begin
        obs_t e;
        obs_t a;
        logic fell;
        fell = prev_rst && !rst_n;
        prev_rst = rst_n;
        if (fell) begin
            #1;
            a = {event_ready, event_time, event_count, overflow};
            n_cmp++;
            if (a !== 21'h0) begin
                n_bad++;
                $display("FAIL reset_async t=%0t got rdy=%b time=%h cnt=%0d ovf=%b want all zero",
                         $time, a.rdy, a.tm, a.cnt, a.ovf);
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {event_ready, event_time, event_count, overflow};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t got rdy=%b time=%h cnt=%0d ovf=%b want rdy=%b time=%h cnt=%0d ovf=%b",
                         $time, a.rdy, a.tm, a.cnt, a.ovf, e.rdy, e.tm, e.cnt, e.ovf);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [15:0] ts);
        time_in = ts;
        pushbutton = 1'b0;
        step(8);
        pushbutton = 1'b1;
        step(8);
    endtask

    task automatic ack(input int n);
        event_ack = 1'b1;
        step(n);
        event_ack = 1'b0;
    endtask

    task automatic pulse_reset(input int n);
        #2 rst_n = 1'b0;
        step(n);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        step(3);
        #2 rst_n = 1'b1;
        step(2);

        // clean press, release adds nothing
        press(16'h0010);
        step(4);
        ack(1);
        step(2);

        // bounce: 3 low, 1 high, then held low
        time_in = 16'h0020;
        pushbutton = 1'b0;
        step(3);
        pushbutton = 1'b1;
        step(1);
        pushbutton = 1'b0;
        step(10);
        pushbutton = 1'b1;
        step(8);
        ack(1);
        step(2);

        // ordering
        press(16'h0001);
        press(16'h0002);
        press(16'h0003);
        ack(3);
        step(2);

        // overflow then clear
        for (int i = 1; i <= 5; i++) press(16'h0100 + 16'(i));
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        step(2);

        // full FIFO: ack lands on the edge the press completes
        time_in = 16'h0200;
        pushbutton = 1'b0;
        step(5);
        ack(1);
        step(2);
        pushbutton = 1'b1;
        step(8);
        ack(4);
        step(2);

        // reset with queued events and button held low
        press(16'h0300);
        press(16'h0301);
        time_in = 16'h0400;
        pushbutton = 1'b0;
        step(2);
        pulse_reset(2);
        step(10);
        pushbutton = 1'b1;
        step(8);
        ack(2);
        step(2);

        // randomized traffic
        repeat (300) begin
            pushbutton = 1'($urandom_range(0, 1));
            time_in = 16'($urandom);
            event_ack = ($urandom_range(0, 3) == 0);
            clr_ovf = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 59) == 0) pulse_reset(1);
            step($urandom_range(1, 10));
        end

        pushbutton = 1'b1;
        event_ack = 1'b0;
        clr_ovf = 1'b0;
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
